mult_booth: RTL and testbench

Sequential signed 32x32 multiplier for the CPU's HI/LO unit, the complement of the iterative divider. It computes the 64-bit two's-complement product of A and B with radix-2 Booth recoding, one bit per clock. The result goes to the same HI/LO register pair that the divider targets. A start/busy/done handshake lets the control unit stall until the result is valid.

---
 rtl/mult_booth_if.sv | 27 ++
 rtl/mult_booth.sv | 116 +++++++++++
 tb/tb_mult_booth.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mult_booth_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master (control unit) drives start and the operands and observes the
// results; the slave (the multiplier) drives the results back.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic [CW-1:0]    counter;

  modport master (
    output start, A, B,
    input  HI, LO, busy, done, counter
  );

  modport slave (
    input  start, A, B,
    output HI, LO, busy, done, counter
  );
endinterface

// File: rtl/mult_booth.sv
// Sequential signed WIDTHxWIDTH multiplier using radix-2 Booth recoding,
// one recoding step per clock. The product lands in the HI/LO pair with a
// single-cycle done pulse. The accumulator carries one extra bit so that
// subtracting the most negative multiplicand cannot overflow.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mult_booth_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q1_reg;
  logic [CW-1:0]    counter_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;

  // Booth recoding of the current bit pair {Q[0], q_1}
  logic             op_en;
  logic             op_sub;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  assign op_en  = q_reg[0] ^ q1_reg;
  assign op_sub = q_reg[0] & ~q1_reg;
  assign m_ext  = {m_reg[WIDTH-1], m_reg};

  // Per-bit conditional inversion: subtraction is ~M + 1, the +1 enters as carry-in
  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_addend
      assign addend[gi] = op_en & (m_ext[gi] ^ op_sub);
    end
  endgenerate

  assign sum = acc_reg + addend + (WIDTH + 1)'(op_sub);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: leave RUN on the edge where the last Booth step completes
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (counter_reg == CW'(WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, Booth step with arithmetic shift, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      q1_reg      <= 1'b0;
      counter_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            m_reg       <= bus.A;
            acc_reg     <= '0;
            q_reg       <= bus.B;
            q1_reg      <= 1'b0;
            counter_reg <= '0;
          end
        end
        RUN: begin
          acc_reg     <= {sum[WIDTH], sum[WIDTH:1]};
          q_reg       <= {sum[0], q_reg[WIDTH-1:1]};
          q1_reg      <= q_reg[0];
          counter_reg <= counter_reg + 1'b1;
        end
        FINISH: begin
          hi_reg   <= acc_reg[WIDTH-1:0];
          lo_reg   <= q_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.HI      = hi_reg;
  assign bus.LO      = lo_reg;
  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = done_reg;
  assign bus.counter = counter_reg;
endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth: hand-computed products, handshake timing,
// ignored start while busy, start in the done cycle, and reset corner cases.
module tb_mult_booth;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   busy_cnt;
  int   done_cnt;

  mult_booth_if #(.WIDTH(32)) bus ();

  mult_booth #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle start; returns just after the accept edge E0
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'hCAFE_F00D;
  endtask

  // Wait (bounded) for done; counts edges waited and busy samples seen
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(a, b);
    wait_done(cyc, busy_cnt);
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_prod"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
    $display("op %s: A=%h B=%h -> HI=%h LO=%h after %0d cycles", tag, a, b, bus.HI, bus.LO, cyc);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("rst_ctl", {61'd0, bus.busy, bus.done, 1'b0}, 64'd0);
    check("rst_counter", 64'(bus.counter), 64'd0);

    // 7 x 6 with full handshake timing
    start_op(32'd7, 32'd6);
    check("7x6_busy_e0", 64'(bus.busy), 64'd1);
    check("7x6_cnt_e0", 64'(bus.counter), 64'd0);
    wait_done(cyc, busy_cnt);
    check("7x6_lat", 64'(cyc), 64'd33);
    check("7x6_busy_cycles", 64'(busy_cnt), 64'd32);
    check("7x6_prod", {bus.HI, bus.LO}, 64'h0000_0000_0000_002A);
    check("7x6_cnt_end", 64'(bus.counter), 64'd32);
    $display("op 7x6: HI=%h LO=%h latency=%0d busy=%0d", bus.HI, bus.LO, cyc, busy_cnt);
    tick();
    check("7x6_done_pulse", 64'(bus.done), 64'd0);
    check("7x6_hold", {bus.HI, bus.LO}, 64'h0000_0000_0000_002A);
    check("7x6_cnt_hold", 64'(bus.counter), 64'd32);

    // Signed and boundary operands
    run_case("m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_case("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_case("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_case("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_case("minx1", 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);

    // Start while busy is ignored; start in the done cycle is accepted
    tick();
    start_op(32'd2, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    check("ign_cnt10", 64'(bus.counter), 64'd10);
    bus.start = 1'b1;
    bus.A     = 32'd9;
    bus.B     = 32'd9;
    tick();
    bus.start = 1'b0;
    check("ign_cnt11", 64'(bus.counter), 64'd11);
    wait_done(cyc, busy_cnt);
    check("ign_lat", 64'(cyc), 64'd22);
    check("ign_prod", {bus.HI, bus.LO}, 64'h0000_0000_0000_0006);
    $display("op 2x3 with ignored start: HI=%h LO=%h", bus.HI, bus.LO);
    start_op(32'd9, 32'd9);
    check("donecyc_busy", 64'(bus.busy), 64'd1);
    check("donecyc_cnt", 64'(bus.counter), 64'd0);
    check("donecyc_hold", {bus.HI, bus.LO}, 64'h0000_0000_0000_0006);
    wait_done(cyc, busy_cnt);
    check("donecyc_lat", 64'(cyc), 64'd33);
    check("donecyc_prod", {bus.HI, bus.LO}, 64'h0000_0000_0000_0051);
    $display("op 9x9 started in done cycle: HI=%h LO=%h", bus.HI, bus.LO);

    // Reset mid-operation aborts with no done
    tick();
    run_case("2x3", 32'd2, 32'd3, 32'h0, 32'h6);
    tick();
    start_op(32'd4, 32'd4);
    for (int i = 0; i < 10; i++) tick();
    check("abort_cnt10", 64'(bus.counter), 64'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_cnt", 64'(bus.counter), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
      tick();
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    $display("op 4x4 aborted by reset at counter 10");
    run_case("4x4", 32'd4, 32'd4, 32'h0, 32'h10);

    // Reset and start together: reset wins
    tick();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.A     = 32'd5;
    bus.B     = 32'd5;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rststart_busy", 64'(bus.busy), 64'd0);
    check("rststart_cnt", 64'(bus.counter), 64'd0);
    check("rststart_hilo", {bus.HI, bus.LO}, 64'd0);
    tick();
    check("rststart_busy2", 64'(bus.busy), 64'd0);
    check("rststart_cnt2", 64'(bus.counter), 64'd0);
    $display("op reset+start: busy=%b counter=%0d", bus.busy, bus.counter);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
